// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame states, PS/2 prefix codes and keyboard-response filter
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    function automatic logic is_drop_code(input logic [7:0] b);
        return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and deglitches the PS/2 lines, then assembles 11-bit frames
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic [FW-1:0] r_fcnt;
    logic          r_filt, r_filt_d;
    logic [WW-1:0] r_wd;
    frame_state_t  r_state, w_next;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          w_fall, w_dat, w_timeout, w_frame_ok;
    assign w_dat      = r_dat_sync[1];
    assign w_fall     = r_filt_d & ~r_filt;
    // a sample event in the same cycle keeps the frame alive
    assign w_timeout  = (r_state != IDLE) && !w_fall && (r_wd == WW'(TIMEOUT_CYCLES - 1));
    assign w_frame_ok = w_dat & (^{r_shift, r_par});
    assign o_rx_byte  = r_shift;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_fcnt     <= '0;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
            r_filt_d   <= r_filt;
            if (r_clk_sync[1] == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_sync[1];
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    w_next = w_dat ? IDLE : DATA;
                DATA:    w_next = (r_bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  w_next = STOP;
                default: w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wd       <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_err   <= 1'b0;
        end else begin
            r_wd       <= (w_fall || w_timeout || r_state == IDLE) ? '0 : r_wd + WW'(1);
            o_rx_valid <= 1'b0;
            o_rx_err   <= w_timeout;
            if (w_fall) begin
                case (r_state)
                    IDLE:   r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY: r_par <= w_dat;
                    default: begin
                        o_rx_valid <= w_frame_ok;
                        o_rx_err   <= ~w_frame_ok;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns received Set-2 bytes into make/break key events,
// folding the F0/E0 prefixes into flags and discarding keyboard response codes
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keyboard_code,
    output logic       makeBreak,
    output logic       extended,
    output logic       code_valid,
    output logic       frame_error
);
    logic [7:0] w_rx_byte;
    logic       w_rx_valid, w_rx_err;
    logic       r_brk_pend, r_ext_pend;
    logic [7:0] r_code;
    logic       r_make, r_ext, r_valid, r_err;
    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock     (clock),
        .resetn    (resetn),
        .i_ps2_clk (ps2_clk),
        .i_ps2_dat (ps2_dat),
        .o_rx_byte (w_rx_byte),
        .o_rx_valid(w_rx_valid),
        .o_rx_err  (w_rx_err)
    );
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
            r_code     <= 8'h00;
            r_make     <= 1'b0;
            r_ext      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= w_rx_err;
            if (w_rx_err) begin
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
            end else if (w_rx_valid) begin
                if (w_rx_byte == PS2_BREAK) begin
                    r_brk_pend <= 1'b1;
                end else if (w_rx_byte == PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else begin
                    r_brk_pend <= 1'b0;
                    r_ext_pend <= 1'b0;
                    if (!is_drop_code(w_rx_byte)) begin
                        r_code  <= w_rx_byte;
                        r_make  <= ~r_brk_pend;
                        r_ext   <= r_ext_pend;
                        r_valid <= 1'b1;
                    end
                end
            end
        end
    end
    assign keyboard_code = r_code;
    assign makeBreak     = r_make;
    assign extended      = r_ext;
    assign code_valid    = r_valid;
    assign frame_error   = r_err;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: drives PS/2 frames and compares key events with a
// byte-level model of the prefix/drop rules
module tb_ps2_scancode_decoder;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] keyboard_code;
    logic       makeBreak, extended, code_valid, frame_error;

    ps2_scancode_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
        .clock(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .keyboard_code(keyboard_code), .makeBreak(makeBreak), .extended(extended),
        .code_valid(code_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0, n_cv = 0, n_fe = 0, n_both = 0, cv_cyc = 0, fe_cyc = 0, last_fall = 0;
    int n_checks = 0, n_pass = 0;
    int e_cv = 0, e_fe = 0;
    logic       m_brk = 0, m_ext = 0, m_mb = 0, m_exo = 0;
    logic [7:0] m_code = 8'h00;
    logic [7:0] drops [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (code_valid) begin n_cv++; cv_cyc = cyc; end
        if (frame_error) begin n_fe++; fe_cyc = cyc; end
        if (code_valid && frame_error) n_both++;
    end

    // kind: 0 good, 1 bad parity, 2 bad stop; glitch = bit index whose high phase gets a short low blip
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits, input int glitch);
        logic [10:0] f;
        f = {kind != 2, (~^b) ^ (kind == 1), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (25) @(negedge clk);
            ps2_clk = 1'b1;
            if (i == glitch) begin
                repeat (5) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (13) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
        ps2_dat = 1'b1;
    endtask

    task automatic model(input logic [7:0] b, input bit good);
        if (!good) begin
            e_fe++;
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                e_cv++;
                m_code = b;
                m_mb = !m_brk;
                m_exo = m_ext;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic do_frame(input logic [7:0] b, input int kind);
        send_frame(b, kind, 11, -1);
        model(b, kind == 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (keyboard_code !== 8'h00) $display("FAIL reset code got %h want 00", keyboard_code); else n_pass++;
        n_checks++; if (makeBreak !== 1'b0) $display("FAIL reset makeBreak got %b want 0", makeBreak); else n_pass++;
        n_checks++; if (extended !== 1'b0) $display("FAIL reset extended got %b want 0", extended); else n_pass++;
        n_checks++; if (code_valid !== 1'b0) $display("FAIL reset code_valid got %b want 0", code_valid); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL reset frame_error got %b want 0", frame_error); else n_pass++;
        resetn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_make;
        do_frame(8'h1C, 0);
        n_checks++; if (n_cv !== e_cv) $display("FAIL make cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        n_checks++; if (n_fe !== e_fe) $display("FAIL make fe_count got %0d want %0d", n_fe, e_fe); else n_pass++;
        n_checks++; if (keyboard_code !== 8'h1C) $display("FAIL make code got %h want 1c", keyboard_code); else n_pass++;
        n_checks++; if (makeBreak !== 1'b1) $display("FAIL make makeBreak got %b want 1", makeBreak); else n_pass++;
        n_checks++; if (extended !== 1'b0) $display("FAIL make extended got %b want 0", extended); else n_pass++;
        // 2 sync + 4 filter + detect + rx_valid + code_valid registers after the stop-bit fall
        n_checks++;
        if (cv_cyc - last_fall < 7 || cv_cyc - last_fall > 9)
            $display("FAIL make latency got %0d want 7..9", cv_cyc - last_fall);
        else n_pass++;
    endtask

    task automatic test_break;
        do_frame(8'hF0, 0);
        n_checks++; if (n_cv !== e_cv) $display("FAIL break_prefix cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        do_frame(8'h1C, 0);
        n_checks++; if (n_cv !== e_cv) $display("FAIL break cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        n_checks++; if (keyboard_code !== 8'h1C) $display("FAIL break code got %h want 1c", keyboard_code); else n_pass++;
        n_checks++; if (makeBreak !== 1'b0) $display("FAIL break makeBreak got %b want 0", makeBreak); else n_pass++;
    endtask

    task automatic test_extended;
        do_frame(8'hE0, 0);
        do_frame(8'hF0, 0);
        do_frame(8'h75, 0);
        n_checks++; if (n_cv !== e_cv) $display("FAIL ext cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        n_checks++; if ({keyboard_code, makeBreak, extended} !== {8'h75, 1'b0, 1'b1})
            $display("FAIL ext outputs got %h/%b/%b want 75/0/1", keyboard_code, makeBreak, extended); else n_pass++;
        do_frame(8'hFA, 0);
        n_checks++; if (n_cv !== e_cv) $display("FAIL drop cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        n_checks++; if ({keyboard_code, makeBreak, extended} !== {8'h75, 1'b0, 1'b1})
            $display("FAIL drop held got %h/%b/%b want 75/0/1", keyboard_code, makeBreak, extended); else n_pass++;
    endtask

    task automatic test_errors;
        do_frame(8'h1C, 1);
        n_checks++; if (n_fe !== e_fe) $display("FAIL parity fe_count got %0d want %0d", n_fe, e_fe); else n_pass++;
        n_checks++; if (n_cv !== e_cv) $display("FAIL parity cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        do_frame(8'hF0, 0);
        do_frame(8'h1C, 2);
        n_checks++; if (n_fe !== e_fe) $display("FAIL stop fe_count got %0d want %0d", n_fe, e_fe); else n_pass++;
        do_frame(8'h1C, 0);
        n_checks++; if (n_cv !== e_cv) $display("FAIL err_clear cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        n_checks++; if (makeBreak !== 1'b1) $display("FAIL err_clear makeBreak got %b want 1", makeBreak); else n_pass++;
    endtask

    task automatic test_timeout;
        send_frame(8'h3C, 0, 6, -1);
        model(8'h00, 1'b0);
        repeat (2100) @(negedge clk);
        n_checks++; if (n_fe !== e_fe) $display("FAIL timeout fe_count got %0d want %0d", n_fe, e_fe); else n_pass++;
        n_checks++;
        if (fe_cyc - last_fall < 2000 || fe_cyc - last_fall > 2020)
            $display("FAIL timeout delay got %0d want 2000..2020", fe_cyc - last_fall);
        else n_pass++;
        do_frame(8'h29, 0);
        n_checks++; if ({keyboard_code, makeBreak} !== {8'h29, 1'b1})
            $display("FAIL after_timeout got %h/%b want 29/1", keyboard_code, makeBreak); else n_pass++;
    endtask

    task automatic test_glitch;
        send_frame(8'h5A, 0, 11, 3);
        model(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        n_checks++; if (n_cv !== e_cv) $display("FAIL glitch cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        n_checks++; if (keyboard_code !== 8'h5A) $display("FAIL glitch code got %h want 5a", keyboard_code); else n_pass++;
    endtask

    task automatic test_reset_mid;
        send_frame(8'h5A, 0, 5, -1);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({keyboard_code, makeBreak, extended, code_valid, frame_error} !== 12'h000)
            $display("FAIL mid_reset outputs got %h/%b/%b/%b/%b want 00/0/0/0/0",
                     keyboard_code, makeBreak, extended, code_valid, frame_error); else n_pass++;
        {m_brk, m_ext, m_mb, m_exo, m_code} = '0;
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        do_frame(8'h5A, 0);
        n_checks++; if (n_cv !== e_cv) $display("FAIL post_reset cv_count got %0d want %0d", n_cv, e_cv); else n_pass++;
        n_checks++; if ({keyboard_code, makeBreak} !== {8'h5A, 1'b1})
            $display("FAIL post_reset got %h/%b want 5a/1", keyboard_code, makeBreak); else n_pass++;
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = (r <= 1) ? 8'hF0 : (r == 2) ? 8'hE0 : (r == 3) ? drops[$urandom_range(0, 5)] : 8'($urandom);
            do_frame(b, (r == 4) ? 1 : 0);
            n_checks++; if (n_cv !== e_cv || n_fe !== e_fe)
                $display("FAIL rand%0d counts got %0d/%0d want %0d/%0d", n, n_cv, n_fe, e_cv, e_fe); else n_pass++;
            n_checks++; if ({keyboard_code, makeBreak, extended} !== {m_code, m_mb, m_exo})
                $display("FAIL rand%0d outputs got %h/%b/%b want %h/%b/%b",
                         n, keyboard_code, makeBreak, extended, m_code, m_mb, m_exo); else n_pass++;
        end
        n_checks++; if (n_both !== 0) $display("FAIL overlap got %0d want 0", n_both); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_extended;
        test_errors;
        test_timeout;
        test_glitch;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
